// File: rtl/fetch_queue_pkg.sv
// Shared CPU definitions for the fetch front end: instruction/PC widths,
// the PC step, opcode field position and the queue entry layout.
package fetch_queue_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;

    localparam logic [PC_W-1:0] PC_INC  = 16'd2;
    localparam logic [3:0]      OP_HALT = 4'hF;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_STOPPED = 1'b1
    } fq_state_e;

    // One queued fetch: address it came from plus the instruction word.
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    // Extract the major opcode field of an instruction word.
    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// Bundle of fetch-queue signals: instruction-memory port, redirect/halt
// controls from the pipeline and the head-of-queue view given to IF/ID.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import fetch_queue_pkg::*;

    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]    fetch_addr;
    logic [INSTR_W-1:0] im_instr;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               id_ready;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic [PC_W-1:0]    out_pc_plus2;
    logic [OCC_W-1:0]   occupancy;
    logic               stopped;

    // The fetch queue itself.
    modport master (
        output fetch_addr,
        input  im_instr,
        input  redirect,
        input  redirect_pc,
        input  halt,
        input  id_ready,
        output out_valid,
        output out_instr,
        output out_pc,
        output out_pc_plus2,
        output occupancy,
        output stopped
    );

    // The surrounding pipeline / memory environment.
    modport slave (
        input  fetch_addr,
        output im_instr,
        output redirect,
        output redirect_pc,
        output halt,
        output id_ready,
        input  out_valid,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus2,
        input  occupancy,
        input  stopped
    );

endinterface : fetch_queue_if

// File: rtl/fetch_queue_storage.sv
// Entry storage for the fetch queue: DEPTH registered {pc, instr} slots,
// one write port, a combinational read port and a synchronous clear.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  fq_entry_t     wdata_i,
    input  logic [AW-1:0] raddr_i,
    output fq_entry_t     rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Slot array: cleared on reset so the head reads zero while empty.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{pc: 16'h0000, instr: 16'h0000};
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fq_storage

// File: rtl/fetch_queue.sv
// Instruction prefetch queue in front of IF/ID. Owns the fetch PC, reads
// instruction memory combinationally, buffers {pc, instr} pairs and hands
// the oldest one to decode. Handles redirect-with-flush and HALT stop.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter logic [PC_W-1:0]  RESET_PC = 16'h0000,
    parameter logic [3:0]       HALT_OP  = OP_HALT
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    fq_state_e        state_q;
    logic             stopped_q;
    logic [PC_W-1:0]  pc_q,     pc_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q,    occ_d;

    logic      full_s;
    logic      empty_s;
    logic      enq_s;
    logic      deq_s;
    logic      halt_op_s;
    fq_entry_t wentry_s;
    fq_entry_t head_s;

    // Full/empty come from registered occupancy only: a slot freed by a
    // dequeue this cycle is not reusable until the next one.
    assign full_s    = (occ_q == OCC_FULL);
    assign empty_s   = (occ_q == {OCC_W{1'b0}});
    assign enq_s     = !full_s && !bus.halt && !bus.redirect && (state_q == ST_RUN);
    assign deq_s     = !empty_s && bus.id_ready && !bus.redirect;
    assign halt_op_s = (opcode_of(bus.im_instr) == HALT_OP);
    assign wentry_s  = '{pc: pc_q, instr: bus.im_instr};

    // Next-state for fetch PC, pointers and occupancy; redirect flushes.
    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (bus.redirect) begin
            pc_d     = bus.redirect_pc;
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            occ_d    = {OCC_W{1'b0}};
        end else begin
            if (enq_s) begin
                pc_d     = pc_q + PC_INC;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                pc_d     = pc_q;
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (enq_s && !deq_s) begin
                occ_d = occ_q + OCC_ONE;
            end else if (!enq_s && deq_s) begin
                occ_d = occ_q - OCC_ONE;
            end else begin
                occ_d = occ_q;
            end
        end
    end

    // Datapath registers: fetch PC, ring pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            occ_q    <= {OCC_W{1'b0}};
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Run/stop FSM: a HALT opcode that gets enqueued stops fetching until a
    // redirect; stopped is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            stopped_q <= 1'b0;
        end else if (bus.redirect) begin
            state_q   <= ST_RUN;
            stopped_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (enq_s && halt_op_s) begin
                        state_q   <= ST_STOPPED;
                        stopped_q <= 1'b1;
                    end else begin
                        state_q   <= ST_RUN;
                        stopped_q <= 1'b0;
                    end
                end
                ST_STOPPED: begin
                    state_q   <= ST_STOPPED;
                    stopped_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_RUN;
                    stopped_q <= 1'b0;
                end
            endcase
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk_i   (clk),
        .clr_i   (rst),
        .we_i    (enq_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (wentry_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_s)
    );

    assign bus.fetch_addr   = pc_q;
    assign bus.out_valid    = !empty_s;
    assign bus.out_instr    = head_s.instr;
    assign bus.out_pc       = head_s.pc;
    assign bus.out_pc_plus2 = head_s.pc + PC_INC;
    assign bus.occupancy    = occ_q;
    assign bus.stopped      = stopped_q;

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: streaming, back-pressure, redirect,
// HALT stop, halt stall, PC wrap and reset/redirect priority.
module tb_fetch_queue;

    logic clk;
    logic rst;
    logic halt_en;
    int   n_checks;
    int   n_fail;

    fetch_queue_if #(.DEPTH(4)) bus ();

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (16'h0000),
        .HALT_OP  (4'hF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory model: word = 16'h1000 + addr, HALT at 6 if enabled.
    assign bus.im_instr = (halt_en && (bus.fetch_addr == 16'h0006)) ? 16'hF000
                                                                    : (16'h1000 + bus.fetch_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [15:0] pc, input logic [2:0] occ);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_pc"},    32'(bus.out_pc), 32'(pc));
        chk({tag, "_instr"}, 32'(bus.out_instr), 32'(16'h1000 + pc));
        chk({tag, "_pc2"},   32'(bus.out_pc_plus2), 32'(pc + 16'd2));
        chk({tag, "_occ"},   32'(bus.occupancy), 32'(occ));
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        halt_en         = 1'b0;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.halt        = 1'b0;
        bus.id_ready    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_occ",   32'(bus.occupancy), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_instr", 32'(bus.out_instr), 32'd0);
        chk("rst_pc",    32'(bus.out_pc), 32'd0);
        chk("rst_pc2",   32'(bus.out_pc_plus2), 32'd2);
        chk("rst_fa",    32'(bus.fetch_addr), 32'd0);
        chk("rst_stop",  32'(bus.stopped), 32'd0);

        // Streaming with id_ready=1: one entry in flight, head lags by one
        rst          = 1'b0;
        bus.id_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("stream_fa", 32'(bus.fetch_addr), 32'(2 * k));
            chk_head("stream", 16'(2 * (k - 1)), 3'd1);
        end

        // Back-pressure from reset: fill to DEPTH, then hold
        rst          = 1'b1;
        bus.id_ready = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step(); step();
        chk("fill_occ", 32'(bus.occupancy), 32'd4);
        chk("fill_fa",  32'(bus.fetch_addr), 32'h8);
        chk_head("fill", 16'h0000, 3'd4);
        step();
        chk("full_hold_occ", 32'(bus.occupancy), 32'd4);
        chk("full_hold_fa",  32'(bus.fetch_addr), 32'h8);
        chk("full_hold_pc",  32'(bus.out_pc), 32'h0);
        bus.id_ready = 1'b1;
        step();
        chk("drain1_fa", 32'(bus.fetch_addr), 32'h8);
        chk_head("drain1", 16'h0002, 3'd3);
        step();
        chk("drain2_fa", 32'(bus.fetch_addr), 32'hA);
        chk_head("drain2", 16'h0004, 3'd3);
        step();
        chk_head("drain3", 16'h0006, 3'd3);
        step();
        chk_head("drain4", 16'h0008, 3'd3);

        // Redirect with 3 entries queued
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        step();
        bus.redirect = 1'b0;
        chk("redir_occ",   32'(bus.occupancy), 32'd0);
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_fa",    32'(bus.fetch_addr), 32'h40);
        step();
        chk("redir_fa2", 32'(bus.fetch_addr), 32'h42);
        chk_head("redir_head", 16'h0040, 3'd1);

        // HALT opcode at address 6
        rst     = 1'b1;
        halt_en = 1'b1;
        step();
        rst = 1'b0;
        step(); step(); step();
        chk("hop_fa3",   32'(bus.fetch_addr), 32'h6);
        chk("hop_stop3", 32'(bus.stopped), 32'd0);
        step();
        chk("hop_stop",  32'(bus.stopped), 32'd1);
        chk("hop_fa",    32'(bus.fetch_addr), 32'h8);
        chk("hop_instr", 32'(bus.out_instr), 32'hF000);
        chk("hop_pc",    32'(bus.out_pc), 32'h6);
        chk("hop_occ",   32'(bus.occupancy), 32'd1);
        step();
        chk("hop_drained_valid", 32'(bus.out_valid), 32'd0);
        chk("hop_drained_fa",    32'(bus.fetch_addr), 32'h8);
        step();
        chk("hop_hold_fa",   32'(bus.fetch_addr), 32'h8);
        chk("hop_hold_stop", 32'(bus.stopped), 32'd1);
        chk("hop_hold_occ",  32'(bus.occupancy), 32'd0);
        halt_en         = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0100;
        step();
        bus.redirect = 1'b0;
        chk("hop_redir_stop", 32'(bus.stopped), 32'd0);
        chk("hop_redir_fa",   32'(bus.fetch_addr), 32'h100);
        step();
        chk("hop_resume_fa", 32'(bus.fetch_addr), 32'h102);
        chk_head("hop_resume", 16'h0100, 3'd1);

        // halt input: stalls fetch, drain continues
        bus.id_ready = 1'b0;
        step();
        chk("pre_halt_occ", 32'(bus.occupancy), 32'd2);
        chk("pre_halt_fa",  32'(bus.fetch_addr), 32'h104);
        bus.halt     = 1'b1;
        bus.id_ready = 1'b1;
        step();
        chk("halt1_fa", 32'(bus.fetch_addr), 32'h104);
        chk_head("halt1", 16'h0102, 3'd1);
        step();
        chk("halt2_fa",    32'(bus.fetch_addr), 32'h104);
        chk("halt2_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("halt3_fa",   32'(bus.fetch_addr), 32'h104);
        chk("halt3_occ",  32'(bus.occupancy), 32'd0);
        chk("halt3_stop", 32'(bus.stopped), 32'd0);
        bus.halt = 1'b0;
        step();
        chk("unhalt_fa", 32'(bus.fetch_addr), 32'h106);
        chk_head("unhalt", 16'h0104, 3'd1);

        // PC wrap through 16'hFFFE
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        step();
        bus.redirect = 1'b0;
        chk("wrap_fa0", 32'(bus.fetch_addr), 32'hFFFE);
        step();
        chk("wrap_fa1",   32'(bus.fetch_addr), 32'h0000);
        chk("wrap_pc",    32'(bus.out_pc), 32'hFFFE);
        chk("wrap_instr", 32'(bus.out_instr), 32'h0FFE);
        chk("wrap_pc2",   32'(bus.out_pc_plus2), 32'h0000);

        // rst beats redirect
        rst             = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0040;
        step();
        rst          = 1'b0;
        bus.redirect = 1'b0;
        chk("prio_fa",  32'(bus.fetch_addr), 32'h0000);
        chk("prio_occ", 32'(bus.occupancy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
